// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream producers share one sink
// through a registered output stage; a grant is held until the source's tlast beat is taken.
module axis_rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = 1,
  parameter int DATA_W  = 8
) (
  input  logic                      axis_clk,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tkeep,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_keep_q, out_keep_d;
  logic                out_last_q, out_last_d;

  logic                out_free_s;
  logic                sel_valid_s;
  logic                sel_keep_s;
  logic                sel_last_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                accept_s;
  logic                any_valid_s;
  logic [IDX_W-1:0]    pick_s;

  // Mux the granted source's beat onto shared select signals
  always_comb begin
    sel_valid_s = 1'b0;
    sel_keep_s  = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_valid_s = (grant_q == IDX_W'(i)) ? s_axis_tvalid[i] : sel_valid_s;
      sel_keep_s  = (grant_q == IDX_W'(i)) ? s_axis_tkeep[i]  : sel_keep_s;
      sel_last_s  = (grant_q == IDX_W'(i)) ? s_axis_tlast[i]  : sel_last_s;
      sel_data_s  = (grant_q == IDX_W'(i)) ? s_axis_tdata[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // Round-robin search: walk from farthest to nearest candidate so the
  // source right after last_grant overrides everything else
  always_comb begin
    int               sum_v;
    logic [IDX_W-1:0] cand_v;
    sum_v       = 0;
    cand_v      = {IDX_W{1'b0}};
    pick_s      = last_grant_q;
    any_valid_s = |s_axis_tvalid;
    for (int k = NUM_SRC; k >= 1; k--) begin
      sum_v  = int'(last_grant_q) + k;
      sum_v  = (sum_v >= NUM_SRC) ? (sum_v - NUM_SRC) : sum_v;
      cand_v = IDX_W'(sum_v);
      pick_s = s_axis_tvalid[cand_v] ? cand_v : pick_s;
    end
  end

  assign out_free_s = !out_valid_q || m_axis_tready;
  assign accept_s   = (state_q == ST_XFER) && out_free_s && sel_valid_s;

  // Per-source ready: only the granted source sees the output stage's space
  always_comb begin
    s_axis_tready = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      s_axis_tready[i] = (state_q == ST_XFER) && out_free_s && (grant_q == IDX_W'(i));
    end
  end

  // Next-state, grant and last-grant bookkeeping
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          grant_d = pick_s;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s && sel_last_s) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output stage: load on accept, drain when free, otherwise hold stable
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_keep_d  = sel_keep_s;
      out_last_d  = sel_last_s;
    end else if (out_free_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge axis_clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= {IDX_W{1'b0}};
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_keep_q   <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == ST_XFER);

endmodule
